// File: rtl/seg7_pkg.sv
// Shared 7-segment display definitions: FSM state encoding, segment constants and BCD decode.
package seg7_pkg;

    typedef enum logic [1:0] {
        StShowUnits = 2'd0,
        StBlankA    = 2'd1,
        StShowTens  = 2'd2,
        StBlankB    = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    // Segment order is gfedcba; codes 10-15 are not BCD and show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_digit_mux_if.sv
// Load/data and display-bus signals of the two-digit 7-segment multiplexer.
interface seg7_digit_mux_if;
    logic       load;
    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic [6:0] segments;
    logic       digit;

    modport master (
        output load, ten_count, unit_count,
        input  segments, digit
    );

    modport slave (
        input  load, ten_count, unit_count,
        output segments, digit
    );
endinterface

// File: rtl/seg7_digit_mux.sv
// Two-digit BCD display multiplexer with dead-time blanking between digits.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module seg7_digit_mux
    import seg7_pkg::*;
#(
    parameter int MUX_PERIOD = 1000,
    parameter int DEAD_TIME  = 12,
    parameter int CNT_BITS   = 10
) (
    input logic             clk,
    input logic             reset,
    seg7_digit_mux_if.slave bus
);

    localparam logic [CNT_BITS-1:0] SHOW_LAST  = CNT_BITS'(MUX_PERIOD - 1);
    localparam logic [CNT_BITS-1:0] BLANK_LAST = CNT_BITS'((DEAD_TIME > 0) ? DEAD_TIME - 1 : 0);
    localparam bit                  HAS_BLANK  = (DEAD_TIME > 0);

    state_e              state_q, state_d, next_state;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [3:0]          ten_q, ten_d;
    logic [3:0]          unit_q, unit_d;
    logic [6:0]          seg_q, seg_d;
    logic                digit_q, digit_d;
    logic                at_last;

    always_comb begin
        state_d    = state_q;
        next_state = state_q;
        cnt_d      = cnt_q + CNT_BITS'(1);
        ten_d      = ten_q;
        unit_d     = unit_q;
        seg_d      = SEG_BLANK;
        digit_d    = digit_q;
        at_last    = 1'b0;

        if (bus.load) begin
            ten_d  = bus.ten_count;
            unit_d = bus.unit_count;
        end

        unique case (state_q)
            StShowUnits: begin
                at_last    = (cnt_q == SHOW_LAST);
                next_state = HAS_BLANK ? StBlankA : StShowTens;
                seg_d      = bcd_to_seg(unit_q);
                digit_d    = 1'b0;
            end
            StBlankA: begin
                at_last    = (cnt_q == BLANK_LAST);
                next_state = StShowTens;
            end
            StShowTens: begin
                at_last    = (cnt_q == SHOW_LAST);
                next_state = HAS_BLANK ? StBlankB : StShowUnits;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                seg_d      = (ten_q == 4'd0) ? SEG_BLANK : bcd_to_seg(ten_q);
`else
                seg_d      = bcd_to_seg(ten_q);
`endif
                digit_d    = 1'b1;
            end
            StBlankB: begin
                at_last    = (cnt_q == BLANK_LAST);
                next_state = StShowUnits;
            end
            default: ;
        endcase

        // Counter restarts on every state entry.
        if (at_last) begin
            cnt_d   = '0;
            state_d = next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StShowUnits;
            cnt_q   <= '0;
            ten_q   <= 4'd0;
            unit_q  <= 4'd0;
            seg_q   <= SEG_BLANK;
            digit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ten_q   <= ten_d;
            unit_q  <= unit_d;
            seg_q   <= seg_d;
            digit_q <= digit_d;
        end
    end

    assign bus.segments = seg_q;
    assign bus.digit    = digit_q;

endmodule

// File: doc/seg7_digit_mux.md
Name: seg7_digit_mux

Overview:
Downstream display stage for the frequency counter.
- Captures a two-digit BCD result (tens, units) on a one-cycle load strobe.
- Time-multiplexes both digits onto a single 7-segment bus plus one digit-select line, for a dual-digit common-segment display.
- Inserts a dead-time blanking interval between digits to suppress ghosting.

Parameters:
- MUX_PERIOD, 1000, clock cycles each digit is shown (must be ≥1; at 12 MHz, ~83 µs per digit).
- DEAD_TIME, 12, clock cycles of blanking between digits (0 = no blank states).
- CNT_BITS, 10, width of the phase counter; must hold max(MUX_PERIOD, DEAD_TIME)-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- load  in  1  one-cycle strobe; capture ten_count/unit_count
- ten_count  in  4  BCD tens digit
- unit_count  in  4  BCD units digit
- segments  out  7  [0]=a … [6]=g, active-high, registered
- digit  out  1  0 = units digit enabled, 1 = tens digit enabled, registered

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk. All state changes occur on posedge clk.
- Latches: ten_latch and unit_latch load from the inputs on any edge where load=1, in any FSM state. Reset clears both to 0. Load during reset is ignored.
- FSM states: SHOW_UNITS → BLANK_A → SHOW_TENS → BLANK_B → SHOW_UNITS.
  - SHOW states last MUX_PERIOD cycles.
  - BLANK states last DEAD_TIME cycles.
  - If DEAD_TIME=0, SHOW states go directly to each other (BLANK states never entered).
- Phase counter:
  - Counts 0..limit-1 in each state.
  - At limit-1 it clears to 0 and the state advances.
  - The counter clears on every state entry.
- Registered outputs (one-cycle latency from state/latch):
  - SHOW_UNITS: segments ← dec(unit_latch), digit ← 0.
  - SHOW_TENS: segments ← dec(ten_latch), digit ← 1.
  - BLANK_A/B: segments ← 0, digit holds its previous value.
- Decode table (gfedcba):
  - 0 → 0111111, 1 → 0000110, 2 → 1011011, 3 → 1001111, 4 → 1100110
  - 5 → 1101101, 6 → 1111101, 7 → 0000111, 8 → 1111111, 9 → 1101111
  - 10–15 (invalid BCD) → 1000000 (dash)
- Load latency: load high in cycle N (latched at edge N) appears on segments after edge N+1, if the FSM is in the matching SHOW state. A load mid-SHOW changes the displayed digit immediately; no shadowing.
- Reset values: state=SHOW_UNITS, counter=0, latches=0, segments=0000000, digit=0. The first cycle after reset deassertion drives segments=0111111, digit=0.
- Reset mid-operation: aborts immediately to the reset values, regardless of state or counter.
- Back-to-back loads: the last one wins; no loss of the final value.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined: in SHOW_TENS, if ten_latch==0, segments ← 0000000 (digit still ← 1). Units are never blanked.
- When undefined: tens digit 0 displays 0111111.

Decomposition:
- Package seg7_pkg contains:
  - FSM state enum (2-bit).
  - SEG_BLANK and SEG_DASH constants.
  - The 16-entry BCD-to-segment decode function, shared with any future display blocks.
- No sub-module: the FSM, counter, latches and output registers form one flat module.

Test Plan (MUX_PERIOD=4, DEAD_TIME=1 unless stated):
1. Reset, no load → segments=0111111/digit=0 for 4 cycles, 0000000 for 1 cycle, 0111111/digit=1 for 4, blank 1; period 10 cycles.
2. load with ten=4, unit=2 → units phase shows 1011011/digit=0, tens phase shows 1100110/digit=1; first change exactly 2 edges after load asserted.
3. DEAD_TIME=0 → digit toggles every 4 cycles with no 0000000 cycles; unit=8 shows 1111111.
4. load ten=12, unit=15 → both phases show 1000000.
5. reset asserted mid-SHOW_TENS with counter=2 → next edge segments=0, digit=0, latches=0; sequence restarts from SHOW_UNITS.
6. SEG7_LEADING_ZERO_BLANK_EN defined, load ten=0, unit=7 → tens phase segments=0000000 with digit=1, units phase 0000111; undefined → tens phase 0111111.
